// File: rtl/hall_call_dispatcher_if.sv
// Hall-call dispatcher bus: hall buttons, both car handshakes and the call status vectors.
// master = dispatcher side, slave = buttons/car sequencers side.
interface hall_call_dispatcher_if #(
    parameter int FLOORS = 5,
    parameter int FW     = 3
);
    logic [FLOORS-1:0] buttons;
    logic [FW-1:0]     ffloor;
    logic              fbusy;
    logic              fack;
    logic              farrive;
    logic              fgo;
    logic [FW-1:0]     ftarget;
    logic [FW-1:0]     sfloor;
    logic              sbusy;
    logic              sack;
    logic              sarrive;
    logic              sgo;
    logic [FW-1:0]     starget;
    logic [FLOORS-1:0] pending;
    logic [FLOORS-1:0] assigned;

    modport master (
        input  buttons, ffloor, fbusy, fack, farrive,
        input  sfloor, sbusy, sack, sarrive,
        output fgo, ftarget, sgo, starget, pending, assigned
    );

    modport slave (
        output buttons, ffloor, fbusy, fack, farrive,
        output sfloor, sbusy, sack, sarrive,
        input  fgo, ftarget, sgo, starget, pending, assigned
    );
endinterface

// File: rtl/hall_call_dispatcher.sv
// Two-car hall-call dispatcher: latches presses, offers one call at a time to the nearest free car.
// Optional macro AGE_PRIORITY_EN: pick the oldest unassigned call instead of the lowest floor.
module hall_call_dispatcher #(
    parameter int FLOORS = 5,
    parameter int FW     = 3,
    parameter int AGE_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    hall_call_dispatcher_if.master bus
);

    typedef enum logic [1:0] {IDLE, PICK, OFFER} state_t;

    state_t            state_q, state_d;
    logic [FLOORS-1:0] pending_q, pending_d;
    logic [FLOORS-1:0] assigned_q, assigned_d;
    logic              fhold_q, fhold_d;
    logic              shold_q, shold_d;
    logic              fgo_q, fgo_d;
    logic              sgo_q, sgo_d;
    logic [FW-1:0]     ftarget_q, ftarget_d;
    logic [FW-1:0]     starget_q, starget_d;
    logic              to_s_q, to_s_d;

    logic [FLOORS-1:0] unassigned;
    logic [FLOORS-1:0] grant_set;
    logic              f_free, s_free;
    logic [FW-1:0]     pick_floor;
    logic              pick_found;
    logic              pick_s;
    logic signed [FW+1:0] f_dist, s_dist;

    function automatic logic [FW-1:0] clamp_floor(input logic [FW-1:0] f);
        if (f > FW'(FLOORS-1)) return FW'(FLOORS-1);
        return f;
    endfunction

    function automatic logic signed [FW+1:0] floor_dist(input logic [FW-1:0] a,
                                                        input logic [FW-1:0] b);
        logic signed [FW+1:0] diff;
        diff = $signed({2'b00, a}) - $signed({2'b00, b});
        return diff[FW+1] ? -diff : diff;
    endfunction

    assign unassigned = pending_q & ~assigned_q;
    assign f_free     = !bus.fbusy && !fhold_q && !fgo_q;
    assign s_free     = !bus.sbusy && !shold_q && !sgo_q;

`ifdef AGE_PRIORITY_EN
    logic [AGE_W-1:0] age_q [FLOORS];
    logic [AGE_W-1:0] age_d [FLOORS];
    logic [AGE_W-1:0] best_age;

    function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] v);
        if (&v) return v;
        return v + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < FLOORS; i++) begin
            age_d[i] = age_q[i];
            if (grant_set[i])       age_d[i] = '0;
            else if (unassigned[i]) age_d[i] = sat_inc(age_q[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FLOORS; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < FLOORS; i++) age_q[i] <= age_d[i];
        end
    end

    // Strict '>' keeps the lowest index on equal ages.
    always_comb begin
        pick_floor = '0;
        pick_found = 1'b0;
        best_age   = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (unassigned[i] && (!pick_found || age_q[i] > best_age)) begin
                pick_floor = FW'(i);
                best_age   = age_q[i];
                pick_found = 1'b1;
            end
        end
    end
`else
    logic unused_age_w;
    assign unused_age_w = (AGE_W > 0);

    always_comb begin
        pick_floor = '0;
        pick_found = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (unassigned[i] && !pick_found) begin
                pick_floor = FW'(i);
                pick_found = 1'b1;
            end
        end
    end
`endif

    // Out-of-range floor inputs are treated as the top floor; ties favour car F.
    assign f_dist = floor_dist(clamp_floor(bus.ffloor), pick_floor);
    assign s_dist = floor_dist(clamp_floor(bus.sfloor), pick_floor);
    assign pick_s = s_free && (!f_free || (s_dist < f_dist));

    always_comb begin
        state_d    = state_q;
        fgo_d      = fgo_q;
        sgo_d      = sgo_q;
        ftarget_d  = ftarget_q;
        starget_d  = starget_q;
        to_s_d     = to_s_q;
        fhold_d    = fhold_q;
        shold_d    = shold_q;
        pending_d  = pending_q | bus.buttons;
        assigned_d = assigned_q;
        grant_set  = '0;

        case (state_q)
            IDLE: begin
                if ((|unassigned) && (f_free || s_free)) state_d = PICK;
            end
            PICK: begin
                if (pick_found && (f_free || s_free)) begin
                    to_s_d = pick_s;
                    if (pick_s) begin
                        sgo_d     = 1'b1;
                        starget_d = pick_floor;
                    end else begin
                        fgo_d     = 1'b1;
                        ftarget_d = pick_floor;
                    end
                    state_d = OFFER;
                end else begin
                    state_d = IDLE;
                end
            end
            OFFER: begin
                // Only the offered car's ack counts; busy does not withdraw the offer.
                if (!to_s_q && bus.fack) begin
                    fgo_d                = 1'b0;
                    grant_set[ftarget_q] = 1'b1;
                    fhold_d              = 1'b1;
                    state_d              = IDLE;
                end else if (to_s_q && bus.sack) begin
                    sgo_d                = 1'b0;
                    grant_set[starget_q] = 1'b1;
                    shold_d              = 1'b1;
                    state_d              = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        assigned_d = assigned_d | grant_set;

        // Arrival clears are applied last so they win over a same-cycle press.
        if (bus.farrive && fhold_q) begin
            pending_d[ftarget_q]  = 1'b0;
            assigned_d[ftarget_q] = 1'b0;
            fhold_d               = 1'b0;
        end
        if (bus.sarrive && shold_q) begin
            pending_d[starget_q]  = 1'b0;
            assigned_d[starget_q] = 1'b0;
            shold_d               = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            assigned_q <= '0;
            fhold_q    <= 1'b0;
            shold_q    <= 1'b0;
            fgo_q      <= 1'b0;
            sgo_q      <= 1'b0;
            ftarget_q  <= '0;
            starget_q  <= '0;
            to_s_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            assigned_q <= assigned_d;
            fhold_q    <= fhold_d;
            shold_q    <= shold_d;
            fgo_q      <= fgo_d;
            sgo_q      <= sgo_d;
            ftarget_q  <= ftarget_d;
            starget_q  <= starget_d;
            to_s_q     <= to_s_d;
        end
    end

    assign bus.fgo      = fgo_q;
    assign bus.sgo      = sgo_q;
    assign bus.ftarget  = ftarget_q;
    assign bus.starget  = starget_q;
    assign bus.pending  = pending_q;
    assign bus.assigned = assigned_q;

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Directed-vector bench for hall_call_dispatcher: per-cycle table plus reset and age sequences.
module tb_hall_call_dispatcher;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    hall_call_dispatcher_if #(.FLOORS(5), .FW(3)) bus ();

    hall_call_dispatcher #(.FLOORS(5), .FW(3), .AGE_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] buttons;
        logic [2:0] ffloor;
        logic       fbusy, fack, farrive;
        logic [2:0] sfloor;
        logic       sbusy, sack, sarrive;
        logic       exp_fgo;
        logic [2:0] exp_ftarget;
        logic       exp_sgo;
        logic [2:0] exp_starget;
        logic [4:0] exp_pending;
        logic [4:0] exp_assigned;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [4:0] b, input int ff, input int fb, input int fa, input int fr,
                       input int sf, input int sb, input int sa, input int sr,
                       input int gf, input int ft, input int gs, input int st,
                       input logic [4:0] p, input logic [4:0] a);
        vec_t v;
        v.buttons = b;
        v.ffloor = 3'(ff); v.fbusy = 1'(fb); v.fack = 1'(fa); v.farrive = 1'(fr);
        v.sfloor = 3'(sf); v.sbusy = 1'(sb); v.sack = 1'(sa); v.sarrive = 1'(sr);
        v.exp_fgo = 1'(gf); v.exp_ftarget = 3'(ft);
        v.exp_sgo = 1'(gs); v.exp_starget = 3'(st);
        v.exp_pending = p; v.exp_assigned = a;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] b, input int ff, input int fb, input int fa, input int fr,
                         input int sf, input int sb, input int sa, input int sr);
        bus.buttons = b;
        bus.ffloor = 3'(ff); bus.fbusy = 1'(fb); bus.fack = 1'(fa); bus.farrive = 1'(fr);
        bus.sfloor = 3'(sf); bus.sbusy = 1'(sb); bus.sack = 1'(sa); bus.sarrive = 1'(sr);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic gf, input logic [2:0] ft,
                                 input logic gs, input logic [2:0] st,
                                 input logic [4:0] p, input logic [4:0] a);
        check({tag, ".fgo"},      32'(bus.fgo),      32'(gf));
        check({tag, ".ftarget"},  32'(bus.ftarget),  32'(ft));
        check({tag, ".sgo"},      32'(bus.sgo),      32'(gs));
        check({tag, ".starget"},  32'(bus.starget),  32'(st));
        check({tag, ".pending"},  32'(bus.pending),  32'(p));
        check({tag, ".assigned"}, 32'(bus.assigned), 32'(a));
    endtask

    initial begin
        logic       got;
        logic [2:0] age_exp;

        checks   = 0;
        failures = 0;
        drive(5'b00000, 0, 0, 0, 0, 0, 0, 0, 0);

        // Far car S takes floor 4; busy before ack keeps the offer; stray farrive ignored
        add(5'b10000, 0,0,0,0, 4,0,0,0, 0,0,0,0, 5'b10000, 5'b00000);
        add(5'b00000, 0,0,0,0, 4,0,0,0, 0,0,0,0, 5'b10000, 5'b00000);
        add(5'b00000, 0,0,0,0, 4,0,0,0, 0,0,1,4, 5'b10000, 5'b00000);
        add(5'b00000, 0,0,0,0, 4,1,0,0, 0,0,1,4, 5'b10000, 5'b00000);
        add(5'b00000, 0,0,0,0, 4,1,1,0, 0,0,0,4, 5'b10000, 5'b10000);
        add(5'b00000, 0,0,0,1, 4,1,0,0, 0,0,0,4, 5'b10000, 5'b10000);
        add(5'b00000, 0,0,0,0, 4,0,0,1, 0,0,0,4, 5'b00000, 5'b00000);
        add(5'b00000, 0,0,0,0, 4,0,0,0, 0,0,0,4, 5'b00000, 5'b00000);
        // Tie goes to F; sack ignored during F offer; arrival beats a same-floor press
        add(5'b00001, 2,0,0,0, 2,0,0,0, 0,0,0,4, 5'b00001, 5'b00000);
        add(5'b00000, 2,0,0,0, 2,0,0,0, 0,0,0,4, 5'b00001, 5'b00000);
        add(5'b00000, 2,0,0,0, 2,0,0,0, 1,0,0,4, 5'b00001, 5'b00000);
        add(5'b00000, 2,0,0,0, 2,0,1,0, 1,0,0,4, 5'b00001, 5'b00000);
        add(5'b00000, 2,0,1,0, 2,0,0,0, 0,0,0,4, 5'b00001, 5'b00001);
        add(5'b00001, 2,0,0,1, 2,0,0,0, 0,0,0,4, 5'b00000, 5'b00000);
        add(5'b00000, 2,0,0,0, 2,0,0,0, 0,0,0,4, 5'b00000, 5'b00000);
        // Two floors pressed together: floor 0 to F, then floor 4 to S; both arrive together
        add(5'b10001, 0,0,0,0, 0,0,0,0, 0,0,0,4, 5'b10001, 5'b00000);
        add(5'b00000, 0,0,0,0, 0,0,0,0, 0,0,0,4, 5'b10001, 5'b00000);
        add(5'b00000, 0,0,0,0, 0,0,0,0, 1,0,0,4, 5'b10001, 5'b00000);
        add(5'b00000, 0,0,1,0, 0,0,0,0, 0,0,0,4, 5'b10001, 5'b00001);
        add(5'b00000, 0,0,0,0, 0,0,0,0, 0,0,0,4, 5'b10001, 5'b00001);
        add(5'b00000, 0,0,0,0, 0,0,0,0, 0,0,1,4, 5'b10001, 5'b00001);
        add(5'b00000, 0,0,0,0, 0,0,1,0, 0,0,0,4, 5'b10001, 5'b10001);
        add(5'b00000, 0,0,0,1, 0,0,0,1, 0,0,0,4, 5'b00000, 5'b00000);
        // Both busy: call waits; S frees up and gets floor 2
        add(5'b00100, 0,1,0,0, 0,1,0,0, 0,0,0,4, 5'b00100, 5'b00000);
        add(5'b00000, 0,1,0,0, 0,1,0,0, 0,0,0,4, 5'b00100, 5'b00000);
        add(5'b00000, 0,1,0,0, 0,1,0,0, 0,0,0,4, 5'b00100, 5'b00000);
        add(5'b00000, 0,1,0,0, 0,0,0,0, 0,0,0,4, 5'b00100, 5'b00000);
        add(5'b00000, 0,1,0,0, 0,0,0,0, 0,0,1,2, 5'b00100, 5'b00000);
        add(5'b00000, 0,1,0,1, 0,0,0,0, 0,0,1,2, 5'b00100, 5'b00000);
        add(5'b00000, 0,1,0,0, 0,0,1,0, 0,0,0,2, 5'b00100, 5'b00100);
        add(5'b00000, 0,1,0,0, 0,0,0,1, 0,0,0,2, 5'b00000, 5'b00000);
        // sfloor=7 clamps to 4: distance 1 to floor 3 beats F's 3
        add(5'b01000, 0,0,0,0, 7,0,0,0, 0,0,0,2, 5'b01000, 5'b00000);
        add(5'b00000, 0,0,0,0, 7,0,0,0, 0,0,0,2, 5'b01000, 5'b00000);
        add(5'b00000, 0,0,0,0, 7,0,0,0, 0,0,1,3, 5'b01000, 5'b00000);
        add(5'b00000, 0,0,0,0, 7,0,1,0, 0,0,0,3, 5'b01000, 5'b01000);
        add(5'b00000, 0,0,0,0, 7,0,0,1, 0,0,0,3, 5'b00000, 5'b00000);

        reset = 1'b1;
        #1 reset = 1'b0;
        #1 check_outputs("reset", 1'b0, 3'd0, 1'b0, 3'd0, 5'b00000, 5'b00000);
        @(negedge clk) reset = 1'b1;
        step();

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].buttons, int'(vecs[k].ffloor), int'(vecs[k].fbusy), int'(vecs[k].fack),
                  int'(vecs[k].farrive), int'(vecs[k].sfloor), int'(vecs[k].sbusy),
                  int'(vecs[k].sack), int'(vecs[k].sarrive));
            step();
            check_outputs($sformatf("v%0d", k), vecs[k].exp_fgo, vecs[k].exp_ftarget,
                          vecs[k].exp_sgo, vecs[k].exp_starget,
                          vecs[k].exp_pending, vecs[k].exp_assigned);
        end

        // Asynchronous reset while F is mid-offer and S holds floor 4
        drive(5'b10000, 0, 0, 0, 0, 4, 0, 0, 0); step();
        drive(5'b00000, 0, 0, 0, 0, 4, 0, 0, 0); step(); step();
        drive(5'b00000, 0, 0, 0, 0, 4, 0, 1, 0); step();
        drive(5'b00001, 0, 0, 0, 0, 4, 0, 0, 0); step();
        drive(5'b00000, 0, 0, 0, 0, 4, 0, 0, 0); step(); step();
        check_outputs("preoffer", 1'b1, 3'd0, 1'b0, 3'd4, 5'b10001, 5'b10000);
        #2 reset = 1'b0;
        #1 check_outputs("async_rst", 1'b0, 3'd0, 1'b0, 3'd0, 5'b00000, 5'b00000);
        @(negedge clk) reset = 1'b1;
        step();

        // Old call on floor 3 versus newer call on floor 1, F released later
        drive(5'b01000, 0, 1, 0, 0, 0, 1, 0, 0); step();
        drive(5'b00000, 0, 1, 0, 0, 0, 1, 0, 0);
        repeat (20) step();
        drive(5'b00010, 0, 1, 0, 0, 0, 1, 0, 0); step();
        drive(5'b00000, 0, 1, 0, 0, 0, 1, 0, 0); step(); step();
        check("age.pending", 32'(bus.pending), 32'(5'b01010));
        check("age.nogo", 32'(bus.fgo | bus.sgo), 32'd0);
        drive(5'b00000, 0, 0, 0, 0, 0, 1, 0, 0);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            step();
            if (bus.fgo) got = 1'b1;
        end
`ifdef AGE_PRIORITY_EN
        age_exp = 3'd3;
`else
        age_exp = 3'd1;
`endif
        check("age.fgo_seen", 32'(got), 32'd1);
        check("age.ftarget", 32'(bus.ftarget), 32'(age_exp));
        check("age.sgo", 32'(bus.sgo), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hall_call_dispatcher.md
Name: hall_call_dispatcher

Overview:
- Hall-call scheduler for the two-car elevator system (cars F and S, floors 0..4).
- Latches hall-button presses into a pending register.
- Picks one unassigned call at a time and offers it to the nearest free car through a go/ack handshake.
- Clears each call when the serving car reports arrival.
- Sits between the hall `buttons` inputs and the per-car sequencers.

Parameters:
- FLOORS, 5, number of floors and width of every per-floor vector.
- FW, 3, floor index width.
- AGE_W, 8, width of the per-floor age counters (used only with AGE_PRIORITY_EN).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- buttons  input  FLOORS  hall-call pulses, one bit per floor
- ffloor  input  FW  current floor of car F
- fbusy  input  1  car F moving or serving a cabin request
- fack  input  1  car F accepts the offered target
- farrive  input  1  one-cycle pulse: car F doors opened at its assigned target
- fgo  output  1  assignment offer to car F
- ftarget  output  FW  offered floor for car F
- sfloor, sbusy, sack, sarrive  input  FW/1/1/1  same as the F versions, for car S
- sgo  output  1  assignment offer to car S
- starget  output  FW  offered floor for car S
- pending  output  FLOORS  outstanding hall calls, assigned or not
- assigned  output  FLOORS  calls currently held by a car

Behaviour:
- Reset (reset=0, asynchronous):
  - pending, assigned, fgo, sgo, ftarget and starget = 0.
  - Both car-holding flags cleared.
  - FSM goes to IDLE.
  - Reset mid-offer drops go immediately.
- Pending register:
  - buttons[i]=1 sets pending[i] on the next edge.
  - A press on a floor that is already pending is ignored.
- Car free: busy=0, holding flag=0 and no go outstanding.
- FSM states IDLE, PICK, OFFER:
  - IDLE -> PICK when (pending & ~assigned) != 0 and at least one car is free.
  - PICK, one cycle:
    - Select the lowest-index unassigned pending floor.
    - Select the free car with the smallest |floor - target|. Tie, or only F free -> F.
    - Register the target and the chosen car, then go to OFFER.
  - OFFER:
    - Chosen car's go=1 and target is held stable until its ack.
    - On ack: go=0, assigned[target]=1, car holding flag=1, FSM -> IDLE.
    - While in OFFER, ack from the other car is ignored.
    - If the chosen car raises busy before ack, the offer is still held; the car must ack.
- Arrival:
  - farrive/sarrive with holding flag set clears pending[t], assigned[t] and the holding flag, where t is that car's registered target.
  - Arrival with holding flag clear is ignored.
- Simultaneous events:
  - Button set and arrival clear on the same floor in the same cycle: clear wins; the call is served.
  - Both arrivals in one cycle: both processed.
- Floor inputs > 4 are clamped to 4 for the distance compare.
- Latency: button at edge n -> pending at n+1 -> PICK at n+2 -> go at n+3 (car free, FSM idle).
- targets hold their last value when go=0.
- A car holds at most one hall call.

Optional Feature:
- Macro: AGE_PRIORITY_EN.
- Defined:
  - Per-floor AGE_W-bit counters increment each cycle while pending & ~assigned, saturating at all-ones.
  - Counters clear when the call is assigned or on reset.
  - PICK selects the floor with the largest age; ties go to the lowest index.
- Undefined:
  - No counters are built.
  - PICK uses strict lowest-index priority.
  - Port list is identical either way.

Test Plan:
- Reset=0 mid-OFFER, fgo=1 -> fgo=0, pending=0 and assigned=0 in the same cycle, without waiting for an edge.
- Both cars idle, ffloor=0, sfloor=4, buttons=5'b10000 pulse -> pending=10000; sgo=1 with starget=4 at edge n+3; after sack, assigned=10000; after sarrive, pending=00000.
- ffloor=2, sfloor=2, buttons=5'b00001 -> fgo=1, ftarget=0 (tie goes to F); sgo stays 0.
- buttons=5'b10001 in one cycle, ffloor=0, sfloor=0 -> floor 0 offered to F first; after fack, floor 4 offered to S.
- fbusy=1, sbusy=1, buttons=5'b00100 -> pending=00100, no go. sbusy drops -> sgo=1, starget=2. farrive pulse with F not holding -> no change.
- With AGE_PRIORITY_EN, both cars busy: press floor 3, wait 20 cycles, press floor 1, free car F -> ftarget=3. Without the macro, same stimulus -> ftarget=1.
